// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - VRAM arbiter between VGA scan-out fetches and a pixel writer
module vga_vram_arbiter #(
  parameter logic [9:0] HBP  = 10'd144,
  parameter logic [9:0] VBP  = 10'd31,
  parameter int         FB_W = 160,
  parameter int         FB_H = 120
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  pix_out,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        vblank
);

  localparam logic [9:0]  HEND    = HBP + 10'd639;
  localparam logic [9:0]  VEND    = VBP + 10'd479;
  localparam logic [14:0] FB_SIZE = 15'(FB_W * FB_H);

  logic        v_act;
  logic        active;
  logic        slot;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [14:0] row15;
  logic [14:0] rd_addr;
  logic [1:0]  rd_p;
  logic [2:0]  hs_p;
  logic [2:0]  vs_p;
  logic [2:0]  de_p;
  logic [7:0]  hold;

  assign v_act  = (vc >= VBP) && (vc <= VEND);
  assign active = v_act && (hc >= HBP) && (hc <= HEND);
  assign slot   = active && (hc[1:0] == 2'b00);
  assign vblank = !v_act;

  // Each framebuffer byte covers a 4x4 block of screen pixels.
  assign row     = 8'((vc - VBP) >> 2);
  assign col     = 8'((hc - HBP) >> 2);
  assign row15   = {7'd0, row};
  assign rd_addr = (row15 << 7) + (row15 << 5) + {7'd0, col};

  // The display owns every fetch slot; the writer gets everything else.
  assign wr_ready = clr_n && !slot;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 15'd0;
      ram_wdata <= 8'd0;
      rd_p      <= 2'b00;
      hs_p      <= 3'b111;
      vs_p      <= 3'b111;
      de_p      <= 3'b000;
      hold      <= 8'd0;
    end else begin
      if (slot) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= rd_addr;
      end else if (wr_valid && wr_ready && (wr_addr < FB_SIZE)) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else begin
        // Out-of-range writes are consumed here without touching the RAM.
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
      // Read data appears two edges after the fetch address is registered.
      rd_p <= {rd_p[0], slot};
      if (rd_p[1]) hold <= ram_rdata;
      hs_p <= {hs_p[1:0], hsync};
      vs_p <= {vs_p[1:0], vsync};
      de_p <= {de_p[1:0], active};
    end
  end

  assign hsync_o = hs_p[2];
  assign vsync_o = vs_p[2];
  assign de_o    = de_p[2];
  assign pix_out = de_o ? hold : 8'd0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - randomized self-checking bench for vga_vram_arbiter
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        hsync;
  logic        vsync;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic [7:0]  pix_out;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        vblank;

  int checks   = 0;
  int failures = 0;

  vga_vram_arbiter dut (
    .clk(clk), .clr_n(clr_n), .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .pix_out(pix_out), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .de_o(de_o), .vblank(vblank)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read RAM seen by the DUT
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model: expected framebuffer contents plus per-cycle history
  localparam int HMAX = 16384;
  logic [7:0]  mref  [0:19199];
  bit          h_act [0:HMAX-1];
  bit          h_slot[0:HMAX-1];
  bit          h_hs  [0:HMAX-1];
  bit          h_vs  [0:HMAX-1];
  logic [7:0]  h_val [0:HMAX-1];
  int          cyc      = 0;
  int          last_rst = -1000;
  bit          seen_rst = 0;
  logic        m_en, m_we;
  logic [14:0] m_addr;
  logic [7:0]  m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rn, input int h, input int v, input bit wv,
                      input int wa, input logic [7:0] wd);
    bit         act, slt, e_de, e_hs, e_vs;
    logic [7:0] e_pix;
    clr_n    = rn;
    hc       = 10'(h);
    vc       = 10'(v);
    hsync    = !(h >= 656 && h < 752);
    vsync    = !(v == 490 || v == 491);
    wr_valid = wv;
    wr_addr  = 15'(wa);
    wr_data  = wd;
    @(negedge clk);
    act = (h >= 144) && (h <= 783) && (v >= 31) && (v <= 510);
    slt = act && (h % 4 == 0);
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, rn && !slt});
    chk("vblank", {31'd0, vblank}, {31'd0, !(v >= 31 && v <= 510)});
    if (seen_rst) begin
      chk("ram_en", {31'd0, ram_en}, {31'd0, m_en});
      chk("ram_we", {31'd0, ram_we}, {31'd0, m_we});
      chk("ram_addr", {17'd0, ram_addr}, {17'd0, m_addr});
      chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, m_wdata});
      if (last_rst >= cyc - 3) begin
        e_de = 0; e_hs = 1; e_vs = 1;
      end else begin
        e_de = h_act[cyc-3]; e_hs = h_hs[cyc-3]; e_vs = h_vs[cyc-3];
      end
      e_pix = 8'd0;
      if (e_de) begin
        for (int s = cyc - 3; s > last_rst && s >= 0; s--) begin
          if (h_slot[s]) begin
            e_pix = h_val[s];
            break;
          end
        end
      end
      chk("de_o", {31'd0, de_o}, {31'd0, e_de});
      chk("hsync_o", {31'd0, hsync_o}, {31'd0, e_hs});
      chk("vsync_o", {31'd0, vsync_o}, {31'd0, e_vs});
      chk("pix_out", {24'd0, pix_out}, {24'd0, e_pix});
    end
    h_act[cyc]  = act;
    h_hs[cyc]   = hsync;
    h_vs[cyc]   = vsync;
    h_slot[cyc] = slt && rn;
    h_val[cyc]  = 8'd0;
    if (!rn) begin
      m_en = 0; m_we = 0; m_addr = 15'd0; m_wdata = 8'd0;
      last_rst = cyc;
      seen_rst = 1;
    end else if (slt) begin
      m_en   = 1; m_we = 0;
      m_addr = 15'(((v - 31) / 4) * 160 + (h - 144) / 4);
      h_val[cyc] = mref[m_addr];
    end else if (wv && wa < 19200) begin
      m_en = 1; m_we = 1; m_addr = 15'(wa); m_wdata = wd;
      mref[wa] = wd;
    end else begin
      m_en = 0; m_we = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v, r;
    for (int i = 0; i < 32768; i++) begin
      ram[i] = 8'($urandom);
      if (i < 19200) mref[i] = ram[i];
    end
    ram[807]  = 8'hA5;
    mref[807] = 8'hA5;
    @(posedge clk);
    #1;

    // Reset with a pending writer request
    step(0, 300, 100, 1, 50, 8'h11);
    step(0, 301, 100, 1, 50, 8'h11);

    // Fetch at vc=51 hc=172, contention at hc=176/177
    for (int h = 140; h <= 220; h++) begin
      if (h == 176 || h == 177) step(1, h, 51, 1, 100, 8'h3C);
      else step(1, h, 51, 1'($urandom), (h < 180) ? 5000 + h : int'($urandom_range(0, 19300)), 8'($urandom));
      if (h == 172) chk("fetch_addr_807", {17'd0, ram_addr}, 32'd807);
      if (h == 177) chk("contention_write_addr", {17'd0, ram_addr}, 32'd100);
    end

    // Out-of-range write in horizontal blanking
    step(1, 790, 51, 1, 19200, 8'h77);
    chk("oor_write_no_en", {31'd0, ram_en}, 32'd0);

    // Full vblank line with writer always requesting
    for (int h = 0; h < 800; h++)
      step(1, h, 515, 1, int'($urandom_range(0, 19199)), 8'($urandom));

    // Last slot of the frame
    for (int h = 760; h < 800; h++) begin
      step(1, h, 510, 0, 0, 8'd0);
      if (h == 780) chk("last_addr_19199", {17'd0, ram_addr}, 32'd19199);
    end

    // Random active lines with writes aimed at the displayed row
    for (int n = 0; n < 3; n++) begin
      v = int'($urandom_range(31, 510));
      for (int h = 0; h < 800; h++)
        step(1, h, v, 1'($urandom), ($urandom_range(0, 1) == 1) ?
             ((v - 31) / 4) * 160 + int'($urandom_range(0, 159)) : int'($urandom_range(0, 19400)),
             8'($urandom));
    end

    // Mid-frame reset inside an active line
    v = int'($urandom_range(31, 510));
    r = int'($urandom_range(150, 700));
    for (int h = 0; h < 800; h++)
      step((h < r || h > r + 1) ? 1'b1 : 1'b0, h, v, 1'($urandom),
           int'($urandom_range(0, 19199)), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port, synchronous-read video RAM between the VGA scan-out path and a pixel writer. It sits between the 640x480 timing generator (hc/vc counters) and the framebuffer RAM. It converts hc/vc into 160x120 framebuffer read addresses, with 4x4 pixel replication, and interleaves writer accesses into the non-fetch cycles. It also delays the sync and enable signals so they stay aligned with the fetched pixel data.

## Interface
- HBP, 144: first active hc value
- VBP, 31: first active vc value
- FB_W, 160: framebuffer width in bytes (one byte per 4x4 screen block)
- FB_H, 120: framebuffer height in rows
- clk  in  1  pixel clock; hc advances by one every clk
- clr_n  in  1  reset; one clock, reset is synchronous and active-low
- hc  in  10  horizontal count, 0..799
- vc  in  10  vertical count, 0..520
- hsync  in  1  timing-generator hsync
- vsync  in  1  timing-generator vsync
- wr_valid  in  1  writer request
- wr_addr  in  15  writer byte address, row*160+col
- wr_data  in  8  writer byte
- wr_ready  out  1  writer grant (combinational)
- ram_en  out  1  RAM access strobe (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  15  RAM address (registered)
- ram_wdata  out  8  RAM write data (registered)
- ram_rdata  in  8  RAM read data, valid the cycle after the RAM samples ram_addr
- pix_out  out  8  pixel byte aligned to hsync_o/vsync_o/de_o
- hsync_o  out  1  hsync delayed 3 clk
- vsync_o  out  1  vsync delayed 3 clk
- de_o  out  1  active-video flag delayed 3 clk
- vblank  out  1  high when vc is outside [VBP, VBP+479] (combinational)

## Operation
- Active window: hc in [144,783] and vc in [31,510]. Then x = hc-144, y = vc-31, row = y>>2, col = x>>2.
- Fetch slot: active window and hc[1:0]==0 (hc = 144,148,…,780). One slot per 4-pixel group.
- At the edge ending a fetch slot, register: ram_en=1, ram_we=0, ram_addr = row*160+col.
  - Compute row*160 as (row<<7)+(row<<5).
- The display owns every fetch slot. In all other cycles wr_ready=1 (while clr_n=1).
- Write accept: wr_valid && wr_ready at an edge.
  - If wr_addr < 19200: that edge registers ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - If wr_addr >= 19200: the request is still accepted (consumed), but ram_en is 0. No other effect.
- In a cycle with neither a slot nor an accept, register ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their values.
- Read capture: 2 edges after a slot's registration edge, latch ram_rdata into the pixel holding register. Hold it for 4 clocks.
- pix_out = holding register when the delayed active flag is set, otherwise 0.
- Delay pipeline: 3-stage shift registers carry hsync, vsync and the active flag. Their outputs are hsync_o, vsync_o and de_o.
- There is no FSM beyond the slot decode. All state is held in counters and pipeline registers.

## Timing
- Reset values (clr_n=0 at an edge):
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, pix_out=0.
  - hsync_o=1, vsync_o=1 (inactive), de_o=0.
  - All pipeline stages take their reset values.
  - wr_ready=0 while clr_n=0, so no write is accepted during reset.
- Reset mid-frame clears the pipeline. Output resumes correctly at the first fetch slot after release. Partial groups before that slot output 0 with de_o following the delayed flag.
- Read path:
  - hc=h is a slot (cycle C). ram_addr is valid in C+1. ram_rdata is valid in C+2.
  - pix_out carries that byte in C+3..C+6, aligned with de_o for pixels h..h+3.
- Display latency: 3 clk, for pix_out, hsync_o, vsync_o and de_o alike.
- Write path: an accept in cycle C puts ram_we=1 in C+1. wr_ready never depends on wr_valid.
- Writer bandwidth:
  - Active line: 3 of every 4 cycles.
  - Blanking and vblank: every cycle.
- Address wrap: there is none. The last slot (hc=780, vc=510) gives address 19199. hc/vc wrap is owned by the timing generator.

## Test plan
- Reset: hold clr_n=0 for 2 clk with wr_valid=1 -> wr_ready=0, ram_en=0, pix_out=0, hsync_o=vsync_o=1, de_o=0.
- Fetch: vc=51, hc=172, ram_rdata=0xA5 returned -> next cycle ram_en=1, ram_we=0, ram_addr=807. pix_out=0xA5 with de_o=1 for 4 clk starting 3 clk after hc=172.
- Contention: wr_valid=1, wr_addr=100, wr_data=0x3C over hc=176..177 in an active row -> wr_ready=0 at 176. Accept at 177, then ram_we=1, ram_addr=100, ram_wdata=0x3C in the next cycle.
- Out-of-range write: wr_addr=19200 in blanking -> accepted (wr_ready=1), and ram_en=0 in the next cycle.
- Blanking throughput: a full line at vc=515 with wr_valid held high -> 800 consecutive accepts, vblank=1, de_o=0, pix_out=0.
- Corner: vc=510, hc=780 -> ram_addr=19199. hc=784 -> no fetch, and de_o falls 3 clk later.
